// File: rtl/uart_rx_fsm.sv
// Control FSM for the UART receiver: tracks oversample and bit counters,
// gates sampler/deserializer/checkers and flags the frame verdict.
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  par_error,
    output logic                  stop_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    state_t                 state_q, state_d;
    logic [PRESCALE_W-1:0]  edge_q, edge_d;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic                   flag_q, flag_d;
    logic                   dv_q, dv_d;
    logic                   pe_q, pe_d;
    logic                   se_q, se_d;
    logic                   bit_end;

    assign bit_end = (edge_q == (Prescale - EDGE_ONE));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            flag_q  <= 1'b0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            flag_q  <= flag_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        bit_d       = bit_q;
        flag_d      = flag_q;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        se_d        = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        dat_samp_en = (state_q != S_IDLE);

        // Every state transition out of a bit happens at bit end, so the
        // wrap below also realigns edge_cnt on each state change.
        if (state_q == S_IDLE) begin
            edge_d = '0;
        end else begin
            edge_d = bit_end ? '0 : edge_q + EDGE_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (!RX_IN) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    strt_chk_en = 1'b1;
                    if (strt_glitch) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    deser_en = 1'b1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_chk_en = 1'b1;
                    flag_d     = par_err;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    stp_chk_en = 1'b1;
                    state_d    = S_IDLE;
                    // A parity failure takes precedence over a stop failure.
                    dv_d       = !flag_q && !stp_err;
                    pe_d       = flag_q;
                    se_d       = stp_err && !flag_q;
                    flag_d     = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign edge_cnt   = edge_q;
    assign bit_cnt    = bit_q;
    assign data_valid = dv_q;
    assign par_error  = pe_q;
    assign stop_error = se_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: per-cycle comparison against a
// frame-timeline model derived from cycle offsets within a frame.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stp_err = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, par_error, stop_error;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int dv_cyc = -1;
    int t0_cyc = 0;

    uart_rx_fsm #(.PRESCALE_W(6), .DATA_WIDTH(8), .BIT_CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .strt_glitch(strt_glitch), .par_err(par_err),
        .stp_err(stp_err), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .par_error(par_error), .stop_error(stop_error)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [17:0] observed();
        return {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                par_chk_en, stp_chk_en, data_valid, par_error, stop_error};
    endfunction

    // Expected outputs k cycles after the cycle in which the start edge was seen.
    function automatic logic [17:0] model(int p, bit pen, bit glitch, bit perr,
                                          bit serr, int k);
        int  last, e, b, j;
        bit  samp, des, sc, pc, sp, dv, pe, se;
        e = 0; b = 0; j = 0;
        samp = 0; des = 0; sc = 0; pc = 0; sp = 0; dv = 0; pe = 0; se = 0;
        last = glitch ? p : p * (10 + int'(pen));
        if (k <= p) begin
            samp = 1; e = k - 1; sc = (k == p);
        end else if (glitch) begin
            samp = 0;
        end else if (k <= 9 * p) begin
            j = k - p - 1; samp = 1; e = j % p; b = j / p; des = (e == p - 1);
        end else if (pen && k <= 10 * p) begin
            samp = 1; e = k - 9 * p - 1; pc = (e == p - 1);
        end else if (k <= last) begin
            samp = 1; e = k - (last - p) - 1; sp = (e == p - 1);
        end else if (k == last + 1) begin
            pe = pen && perr; dv = !pe && !serr; se = serr && !pe;
        end
        return {6'(e), 4'(b), samp, des, sc, pc, sp, dv, pe, se};
    endfunction

    // Caller has RX_IN=0 driven in an IDLE cycle (cycle 0). Runs to the verdict
    // cycle, or returns early after cycle stop_at when stop_at != 0.
    task automatic run_frame(input string name, input int p, input bit pen,
                             input bit glitch, input bit perr, input bit serr,
                             input bit chain, input int stop_at);
        int last, endk, errs0;
        logic [17:0] exp_v, obs_v;
        errs0 = n_err;
        last = glitch ? p : p * (10 + int'(pen));
        endk = last + 1;
        Prescale = 6'(p);
        for (int k = 1; k <= endk; k++) begin
            @(negedge CLK);
            exp_v = model(p, pen, glitch, perr, serr, k);
            obs_v = observed();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL %s k=%0d outputs got=%h want=%h", name, k, obs_v, exp_v);
            end
            if (data_valid === 1'b1) dv_cyc = cyc;
            RX_IN       = (k < endk) ? 1'($urandom_range(0, 1)) : !chain;
            strt_glitch = (k == p) ? glitch : 1'($urandom_range(0, 1));
            PAR_EN      = (k == 9 * p) ? pen : 1'($urandom_range(0, 1));
            par_err     = (k == 10 * p) ? perr : 1'($urandom_range(0, 1));
            stp_err     = (k == last) ? serr : 1'($urandom_range(0, 1));
            if (k == stop_at) begin
                $display("frame %s P=%0d stopped at k=%0d errors=%0d", name, p, k, n_err - errs0);
                return;
            end
        end
        $display("frame %s P=%0d pen=%0d glitch=%0d perr=%0d serr=%0d chain=%0d errors=%0d",
                 name, p, pen, glitch, perr, serr, chain, n_err - errs0);
    endtask

    task automatic start_frame(input string name);
        @(negedge CLK);
        n_cmp++;
        if (observed() !== 18'h0) begin
            n_err++;
            $display("FAIL %s idle_before_start got=%h want=0", name, observed());
        end
        RX_IN  = 1'b0;
        t0_cyc = cyc;
    endtask

    task automatic test_reset();
        #1 RST = 1'b1;
        #2;
        n_cmp++;
        if (observed() !== 18'h0) begin
            n_err++;
            $display("FAIL reset_async got=%h want=0", observed());
        end
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (observed() !== 18'h0) begin
            n_err++;
            $display("FAIL reset_held got=%h want=0", observed());
        end
        RST = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (observed() !== 18'h0) begin
            n_err++;
            $display("FAIL reset_idle got=%h want=0", observed());
        end
        $display("reset test done errors=%0d", n_err);
    endtask

    task automatic test_clean8();
        start_frame("clean8");
        run_frame("clean8", 8, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (dv_cyc - t0_cyc !== 81) begin
            n_err++;
            $display("FAIL clean8_dv_cycle got=%0d want=81", dv_cyc - t0_cyc);
        end
    endtask

    task automatic test_parity16();
        start_frame("par16");
        run_frame("par16", 16, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (dv_cyc - t0_cyc !== 177) begin
            n_err++;
            $display("FAIL par16_dv_cycle got=%0d want=177", dv_cyc - t0_cyc);
        end
    endtask

    task automatic test_glitch();
        start_frame("glitch");
        run_frame("glitch", 8, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_par_stop_err();
        start_frame("perr_serr");
        run_frame("perr_serr", 32, 1, 0, 1, 1, 0, 0);
        start_frame("serr_only");
        run_frame("serr_only", 8, 1, 0, 0, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        int d1;
        start_frame("b2b_a");
        run_frame("b2b_a", 8, 0, 0, 0, 0, 1, 0);
        d1 = dv_cyc;
        run_frame("b2b_b", 8, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (dv_cyc - d1 !== 81) begin
            n_err++;
            $display("FAIL b2b_spacing got=%0d want=81", dv_cyc - d1);
        end
    endtask

    task automatic test_random();
        int  p;
        bit  pen, gl, pe, se, ch, chained;
        chained = 0;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pen = 1'($urandom_range(0, 1));
            gl  = ($urandom_range(0, 4) == 0);
            pe  = 1'($urandom_range(0, 1));
            se  = 1'($urandom_range(0, 1));
            ch  = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!chained) start_frame("rand");
            run_frame("rand", p, pen, gl, pe, se, ch, 0);
            chained = ch;
        end
    endtask

    task automatic test_async_reset();
        start_frame("arst");
        run_frame("arst", 8, 0, 0, 0, 0, 0, 43);
        #2 RST = 1'b1;
        RX_IN = 1'b1;
        #1;
        n_cmp++;
        if (observed() !== 18'h0) begin
            n_err++;
            $display("FAIL arst_immediate got=%h want=0", observed());
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (observed() !== 18'h0) begin
                n_err++;
                $display("FAIL arst_stay_idle cycle=%0d got=%h want=0", i, observed());
            end
        end
        $display("async reset test done errors=%0d", n_err);
    endtask

    initial begin
        test_reset();
        test_clean8();
        test_parity16();
        test_glitch();
        test_par_stop_err();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Control FSM for the UART receiver; the counterpart of the transmitter FSM on the same serial link.
- Tracks the oversampling edge counter and the bit counter.
- Gates the data sampler, the deserializer and the start/parity/stop checkers.
- Issues a single-cycle data_valid when a frame is accepted. RX_IN arrives already synchronized to CLK.

Parameters:
PRESCALE_W, 6, width of Prescale and edge_cnt
DATA_WIDTH, 8, data bits per frame
BIT_CNT_W, 4, width of bit_cnt (must hold DATA_WIDTH-1)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
RX_IN  input  1  synchronized serial line, idle high
Prescale  input  PRESCALE_W  oversampling ratio; 8, 16 or 32 supported
PAR_EN  input  1  1 = frame carries a parity bit
strt_glitch  input  1  start checker result, valid while strt_chk_en=1
par_err  input  1  parity checker result, valid while par_chk_en=1
stp_err  input  1  stop checker result, valid while stp_chk_en=1
edge_cnt  output  PRESCALE_W  oversample index within the current bit
bit_cnt  output  BIT_CNT_W  data bit index 0..DATA_WIDTH-1
dat_samp_en  output  1  sampler enable
deser_en  output  1  deserializer shift strobe
strt_chk_en  output  1  start check strobe
par_chk_en  output  1  parity check strobe
stp_chk_en  output  1  stop check strobe
data_valid  output  1  one-cycle pulse, frame accepted
par_error  output  1  one-cycle pulse, frame rejected on parity
stop_error  output  1  one-cycle pulse, frame rejected on stop bit

Behaviour:
- Reset, asynchronous while RST=1:
  - State = IDLE.
  - edge_cnt=0, bit_cnt=0, internal parity flag=0.
  - All enables and pulses = 0.
  - This applies mid-frame as well; there is no partial-frame recovery.
- States: IDLE, START, DATA, PARITY, STOP.
- "Bit end" means edge_cnt == Prescale-1.
- edge_cnt:
  - Held 0 in IDLE.
  - In the other states it increments every cycle and wraps to 0 at bit end.
  - It also wraps on every state change out of START, DATA or PARITY.
- IDLE:
  - RX_IN=0 -> START on the next edge; edge_cnt=0 on the first START cycle.
  - RX_IN=1 -> stay in IDLE.
- START:
  - At bit end, strt_chk_en=1 for that cycle.
  - strt_glitch=1 -> IDLE.
  - strt_glitch=0 -> DATA with bit_cnt=0.
- DATA:
  - At bit end, deser_en=1 for that cycle and bit_cnt increments.
  - When bit end coincides with bit_cnt == DATA_WIDTH-1:
    - bit_cnt goes to 0.
    - Next state is PARITY if PAR_EN=1, else STOP.
  - PAR_EN is sampled only at that cycle.
- PARITY:
  - At bit end, par_chk_en=1 and the internal parity flag is loaded with par_err.
  - Next state is STOP regardless of par_err.
- STOP:
  - At bit end, stp_chk_en=1 and next state is IDLE.
  - Registered pulses on the next cycle, i.e. the first IDLE cycle:
    - data_valid = !flag & !stp_err.
    - par_error = flag.
    - stop_error = stp_err & !flag.
  - The flag clears at that point.
- dat_samp_en = 1 in every state except IDLE. The sampler times its majority samples from edge_cnt itself.
- All check/shift strobes are combinational decodes of state and edge_cnt. They are exactly one cycle per bit.
- Mutual exclusivity: data_valid, par_error and stop_error are mutually exclusive.
- Back-to-back frames: RX_IN=0 during the data_valid cycle -> START next cycle, with no dead cycle.
- Prescale changes mid-frame are illegal (undefined). Values other than 8, 16 and 32 are unsupported.

Test Plan:
1. Prescale=8, PAR_EN=0, clean frame, falling-edge detection at cycle 0:
   - START occupies cycles 1-8, with strt_chk_en at cycle 8.
   - DATA occupies cycles 9-72; deser_en pulses at cycles 16, 24, ..., 72 (8 pulses), with bit_cnt 0..7 at those pulses.
   - STOP occupies cycles 73-80, with stp_chk_en at cycle 80.
   - data_valid=1 only at cycle 81.
2. Prescale=16, PAR_EN=1, par_err=0, stp_err=0:
   - par_chk_en is a single pulse at edge_cnt=15 in PARITY.
   - data_valid at cycle 177 (1 + 16*11).
3. strt_glitch=1 at the START bit end:
   - IDLE on the next cycle.
   - No deser_en, no data_valid/par_error/stop_error.
   - edge_cnt=0 and bit_cnt=0 afterwards.
4. PAR_EN=1, par_err=1, stp_err=1:
   - STOP is still traversed for a full Prescale cycles.
   - par_error=1 for one cycle; data_valid=0 and stop_error=0.
5. Two back-to-back frames, second start bit low during the first data_valid cycle:
   - START entered the next cycle.
   - Two data_valid pulses spaced exactly 1 + Prescale*10 cycles apart (PAR_EN=0).
6. RST=1 asserted asynchronously mid-DATA (bit_cnt=4, Prescale=8):
   - All outputs 0 and state IDLE immediately, without waiting for a clock edge.
   - After release with RX_IN=1 the FSM stays in IDLE.
